// File: rtl/light_pen_detector.sv
`default_nettype none
// ============================================================================
//  Module      : light_pen_detector
//  Description : Converts the raw light-pen photodiode input into a single
//                cycle write strobe plus the binary pixel address that was
//                lit when the pen saw light. The scan position is delayed to
//                line up with the synchronised pen signal. The pen must stay
//                high on one pixel for DEBOUNCE_CYCLES cycles before a hit
//                is accepted. A continuous dwell on one pixel then yields
//                only one strobe.
//  Ports       : clk      - system clock
//                rst      - synchronous reset, active-high
//                pen_in   - raw photodiode comparator output (asynchronous)
//                pen_en   - detection enable; low aborts and blocks detection
//                scan_row - one-hot row currently lit
//                scan_col - one-hot column currently lit
//                we       - one-cycle write strobe
//                hit_row  - binary row of the last accepted hit
//                hit_col  - binary column of the last accepted hit
//                hit_cnt  - accepted-hit counter, wraps 255 -> 0
//                busy     - high while qualifying, firing or holding off
//  Revision    : 1.0  initial release
// ============================================================================
module light_pen_detector #(
   parameter int SYNC_STAGES     = 2,
   parameter int PEN_LAT         = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLDOFF_CYCLES  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pen_in,
   input  logic       pen_en,
   input  logic [7:0] scan_row,
   input  logic [7:0] scan_col,
   output logic       we,
   output logic [2:0] hit_row,
   output logic [2:0] hit_col,
   output logic [7:0] hit_cnt,
   output logic       busy
);

   localparam int DLY = SYNC_STAGES + PEN_LAT;
   localparam int QW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW  = $clog2(HOLDOFF_CYCLES + 1);

   localparam logic [QW-1:0] QONE = QW'(1);
   localparam logic [QW-1:0] QMAX = QW'(DEBOUNCE_CYCLES);
   localparam logic [HW-1:0] HONE = HW'(1);
   localparam logic [HW-1:0] HMIN = HW'(HOLDOFF_CYCLES - 1);
   localparam logic [HW-1:0] HMAX = HW'(HOLDOFF_CYCLES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_QUAL = 2'd1;
   localparam logic [1:0] ST_FIRE = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   pen_s;
   logic [15:0]            pos_pipe_q [DLY];
   logic [15:0]            pos_dly;
   logic                   pos_ok;

   logic [1:0]             state_q, state_d;
   logic [QW-1:0]          qcnt_q, qcnt_d, qcnt_inc;
   logic [HW-1:0]          hcnt_q, hcnt_d;
   logic [15:0]            cand_q, cand_d;
   logic [2:0]             hit_row_q, hit_col_q;
   logic [7:0]             hit_cnt_q;
   logic                   fire_d;

   function automatic logic onehot8(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

   // Only one-hot vectors ever reach this encoder, so priority is moot.
   function automatic logic [2:0] enc8(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   // ---------------------------------------------------------------------
   // Pen synchroniser and scan-position delay line. The delay covers both
   // the synchroniser and the optical latency, so pos_dly is the pixel
   // that was lit when the light now appearing on pen_s was emitted.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         for (int i = 0; i < DLY; i++) pos_pipe_q[i] <= '0;
      end else begin
         sync_q        <= {sync_q[SYNC_STAGES-2:0], pen_in};
         pos_pipe_q[0] <= {scan_row, scan_col};
         for (int i = 1; i < DLY; i++) pos_pipe_q[i] <= pos_pipe_q[i-1];
      end
   end

   assign pen_s    = sync_q[SYNC_STAGES-1];
   assign pos_dly  = pos_pipe_q[DLY-1];
   assign pos_ok   = onehot8(pos_dly[15:8]) && onehot8(pos_dly[7:0]);
   assign qcnt_inc = qcnt_q + QONE;

   // ---------------------------------------------------------------------
   // Detection state machine
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      qcnt_d  = qcnt_q;
      hcnt_d  = hcnt_q;
      cand_d  = cand_q;
      case (state_q)
         ST_IDLE: begin
            if (pen_en && pen_s && pos_ok) begin
               cand_d = pos_dly;
               qcnt_d = QONE;
               if (DEBOUNCE_CYCLES == 1) state_d = ST_FIRE;
               else                      state_d = ST_QUAL;
            end
         end
         ST_QUAL: begin
            // A change of pixel mid-qualification restarts from IDLE, which
            // may immediately pick up the new pixel on the following cycle.
            if (!pen_s || !pos_ok || (pos_dly != cand_q)) begin
               state_d = ST_IDLE;
               qcnt_d  = '0;
            end else begin
               qcnt_d = qcnt_inc;
               if (qcnt_inc == QMAX) state_d = ST_FIRE;
            end
         end
         ST_FIRE: begin
            state_d = ST_HOLD;
            qcnt_d  = '0;
            hcnt_d  = '0;
         end
         default: begin
            // Leave only once the holdoff has elapsed and the pen has moved
            // off the pixel (or lost light), so one dwell gives one strobe.
            if ((hcnt_q >= HMIN) && ((pos_dly != cand_q) || !pen_s)) begin
               state_d = ST_IDLE;
            end else if (hcnt_q != HMAX) begin
               hcnt_d = hcnt_q + HONE;
            end
         end
      endcase
      if (!pen_en) begin
         state_d = ST_IDLE;
         qcnt_d  = '0;
         cand_d  = '0;
      end
   end

   assign fire_d = (state_d == ST_FIRE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         qcnt_q    <= '0;
         hcnt_q    <= '0;
         cand_q    <= '0;
         hit_row_q <= '0;
         hit_col_q <= '0;
         hit_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         qcnt_q  <= qcnt_d;
         hcnt_q  <= hcnt_d;
         cand_q  <= cand_d;
         // Address and count change together with the strobe so the LED
         // driver sees a consistent address while we is high.
         if (fire_d) begin
            hit_row_q <= enc8(cand_d[15:8]);
            hit_col_q <= enc8(cand_d[7:0]);
            hit_cnt_q <= hit_cnt_q + 8'd1;
         end
      end
   end

   assign we      = (state_q == ST_FIRE);
   assign busy    = (state_q != ST_IDLE);
   assign hit_row = hit_row_q;
   assign hit_col = hit_col_q;
   assign hit_cnt = hit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_light_pen_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_light_pen_detector
//  Description : Self-checking bench for light_pen_detector. A behavioural
//                model derives the expected outputs every cycle from the
//                input history. Directed scenarios add literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_light_pen_detector;

   localparam int S   = 2;
   localparam int PL  = 2;
   localparam int DEB = 4;
   localparam int HO  = 16;
   localparam int D   = S + PL;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pen_in = 1'b0;
   logic       pen_en = 1'b0;
   logic [7:0] scan_row = 8'd0;
   logic [7:0] scan_col = 8'd0;
   logic       we, busy;
   logic [2:0] hit_row, hit_col;
   logic [7:0] hit_cnt;

   light_pen_detector #(
      .SYNC_STAGES    (S),
      .PEN_LAT        (PL),
      .DEBOUNCE_CYCLES(DEB),
      .HOLDOFF_CYCLES (HO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .pen_in  (pen_in),
      .pen_en  (pen_en),
      .scan_row(scan_row),
      .scan_col(scan_col),
      .we      (we),
      .hit_row (hit_row),
      .hit_col (hit_col),
      .hit_cnt (hit_cnt),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cycle = 0;
   bit chk_on = 1'b0;

   always @(posedge clk) cycle <= cycle + 1;

   // Observations of the DUT, compared against literals by the scenarios.
   int we_seen = 0;
   int last_we_cyc = -1;
   bit busy_seen = 1'b0;

   // ------------------------------------------------------------------
   // Behavioural model: pen_s and the delayed position are looked up in
   // the recorded input history; the detector is described by a streak
   // length, a pending strobe and a holdoff age.
   // ------------------------------------------------------------------
   bit          pen_h[$];
   logic [15:0] pos_h[$];
   int          last_rst = 0;
   int          m_streak = 0;
   bit          m_fire = 1'b0;
   int          m_hold = -1;
   logic [15:0] m_cand = '0;
   logic [2:0]  m_row = '0;
   logic [2:0]  m_col = '0;
   logic [7:0]  m_cnt = '0;

   function automatic int bitpos(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v == (8'd1 << i)) return i;
      return 0;
   endfunction

   always @(negedge clk) begin
      int          k;
      bit          ps;
      logic [15:0] pd;
      bit          e_we, e_busy;
      pen_h.push_back(pen_in);
      pos_h.push_back({scan_row, scan_col});
      k  = pen_h.size() - 1;
      ps = (k - S > last_rst) ? pen_h[k-S] : 1'b0;
      pd = (k - D > last_rst) ? pos_h[k-D] : 16'd0;

      e_we   = m_fire;
      e_busy = (m_streak > 0) || m_fire || (m_hold >= 0);
      if (chk_on) begin
         tests++;
         if (we !== e_we || busy !== e_busy || hit_row !== m_row ||
             hit_col !== m_col || hit_cnt !== m_cnt) begin
            fails++;
            if (fails <= 20)
               $display("FAIL model_cycle %0d: we=%b busy=%b row=%0d col=%0d cnt=%0d, required we=%b busy=%b row=%0d col=%0d cnt=%0d",
                        cycle, we, busy, hit_row, hit_col, hit_cnt, e_we, e_busy, m_row, m_col, m_cnt);
         end
      end
      if (we === 1'b1) begin
         we_seen++;
         last_we_cyc = cycle;
      end
      if (busy === 1'b1) busy_seen = 1'b1;

      if (rst) begin
         m_streak = 0; m_fire = 1'b0; m_hold = -1; m_cand = '0;
         m_row = '0; m_col = '0; m_cnt = '0;
         last_rst = k;
      end else if (m_fire) begin
         m_fire = 1'b0;
         m_hold = pen_en ? 0 : -1;
      end else if (!pen_en) begin
         m_streak = 0;
         m_hold   = -1;
      end else if (m_hold >= 0) begin
         if (m_hold >= HO - 1 && (pd != m_cand || !ps)) m_hold = -1;
         else if (m_hold < HO) m_hold++;
      end else if (m_streak > 0 || (ps && $countones(pd[15:8]) == 1 && $countones(pd[7:0]) == 1)) begin
         if (m_streak == 0) begin
            m_cand   = pd;
            m_streak = 1;
         end else if (!ps || pd != m_cand) begin
            m_streak = -1;
         end else begin
            m_streak++;
         end
         if (m_streak == DEB) begin
            m_streak = 0;
            m_fire   = 1'b1;
            m_row    = 3'(bitpos(m_cand[15:8]));
            m_col    = 3'(bitpos(m_cand[7:0]));
            m_cnt    = m_cnt + 8'd1;
         end
         if (m_streak < 0) m_streak = 0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic step(input logic p, input logic e, input logic [7:0] r, input logic [7:0] c);
      pen_in   = p;
      pen_en   = e;
      scan_row = r;
      scan_col = c;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      repeat (6)  step(1'b1, 1'b1, 8'h80, 8'h01);
      repeat (19) step(1'b0, 1'b1, 8'h80, 8'h01);
   endtask

   logic [15:0] lit_sr;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, t0, iter;
      repeat (3) @(posedge clk);
      #1;
      chk_on = 1'b1;
      rst    = 1'b0;
      repeat (5) step(1'b0, 1'b1, 8'h00, 8'h00);
      chk("reset_we", we, 0);
      chk("reset_busy", busy, 0);
      chk("reset_cnt", hit_cnt, 0);
      chk("reset_row", hit_row, 0);

      // 1: steady pen on pixel (2,4)
      w0 = we_seen; t0 = cycle;
      repeat (40) step(1'b1, 1'b1, 8'h04, 8'h10);
      chk("t1_we_count", we_seen - w0, 1);
      chk("t1_we_time", last_we_cyc, t0 + D + DEB);
      chk("t1_row", hit_row, 2);
      chk("t1_col", hit_col, 4);
      chk("t1_cnt", hit_cnt, 1);
      chk("t1_busy_hold", busy, 1);
      repeat (25) step(1'b0, 1'b1, 8'h00, 8'h00);
      chk("t1_busy_after", busy, 0);

      // 2: 3-cycle glitch
      repeat (10) step(1'b0, 1'b1, 8'h04, 8'h10);
      w0 = we_seen;
      repeat (3)  step(1'b1, 1'b1, 8'h04, 8'h10);
      repeat (15) step(1'b0, 1'b1, 8'h04, 8'h10);
      chk("t2_we_count", we_seen - w0, 0);
      chk("t2_busy", busy, 0);
      chk("t2_cnt", hit_cnt, 1);

      // 3: column steps to 5 after two qualified cycles
      w0 = we_seen; t0 = cycle;
      repeat (30) step(1'b1, 1'b1, 8'h04, 8'h20);
      chk("t3_we_count", we_seen - w0, 1);
      chk("t3_we_time", last_we_cyc, t0 + 9);
      chk("t3_col", hit_col, 5);
      chk("t3_row", hit_row, 2);
      chk("t3_cnt", hit_cnt, 2);
      repeat (25) step(1'b0, 1'b1, 8'h00, 8'h00);

      // 4: malformed scan vectors
      w0 = we_seen; busy_seen = 1'b0;
      repeat (20) step(1'b1, 1'b1, 8'h04, 8'h18);
      repeat (20) step(1'b1, 1'b1, 8'h04, 8'h00);
      chk("t4_we_count", we_seen - w0, 0);
      chk("t4_busy_seen", busy_seen, 0);
      repeat (10) step(1'b0, 1'b1, 8'h00, 8'h00);

      // 5a: enable dropped during qualification
      repeat (10) step(1'b0, 1'b1, 8'h20, 8'h40);
      w0 = we_seen;
      repeat (4)  step(1'b1, 1'b1, 8'h20, 8'h40);
      chk("t5_busy_qual", busy, 1);
      repeat (10) step(1'b1, 1'b0, 8'h20, 8'h40);
      repeat (6)  step(1'b0, 1'b0, 8'h20, 8'h40);
      repeat (6)  step(1'b0, 1'b1, 8'h20, 8'h40);
      chk("t5_abort_we", we_seen - w0, 0);

      // 5b: reset while holding off
      w0 = we_seen;
      repeat (20) step(1'b1, 1'b1, 8'h20, 8'h40);
      chk("t5_we_count", we_seen - w0, 1);
      chk("t5_row", hit_row, 5);
      chk("t5_col", hit_col, 6);
      chk("t5_cnt", hit_cnt, 3);
      rst = 1'b1;
      step(1'b1, 1'b1, 8'h20, 8'h40);
      rst = 1'b0;
      chk("t5_rst_cnt", hit_cnt, 0);
      chk("t5_rst_row", hit_row, 0);
      chk("t5_rst_col", hit_col, 0);
      chk("t5_rst_we", we, 0);
      chk("t5_rst_busy", busy, 0);
      repeat (25) step(1'b0, 1'b1, 8'h00, 8'h00);

      // Randomised segments checked by the model
      for (int seg = 0; seg < 200; seg++) begin
         int         len, mode;
         logic [7:0] r, c;
         logic       e;
         len  = $urandom_range(1, 40);
         mode = $urandom_range(0, 3);
         if ($urandom_range(0, 9) < 8) begin
            r = 8'd1 << $urandom_range(0, 7);
            c = 8'd1 << $urandom_range(0, 7);
         end else begin
            r = 8'($urandom);
            c = 8'($urandom);
         end
         e   = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < len; i++) begin
            logic p;
            case (mode)
               0:       p = 1'b0;
               1:       p = 1'b1;
               2:       p = 1'($urandom);
               default: p = (i < len / 2);
            endcase
            step(p, e, r, c);
            rst = 1'b0;
         end
      end
      repeat (30) step(1'b0, 1'b1, 8'h00, 8'h00);

      // 6: frame sweep; the pen only sees pixel (7,0)
      lit_sr = '0;
      for (int f = 0; f < 3; f++) begin
         w0 = we_seen;
         for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
               for (int n = 0; n < 50; n++) begin
                  logic lit;
                  lit = (r == 7) && (c == 0);
                  step(lit_sr[PL-1], 1'b1, 8'(1 << r), 8'(1 << c));
                  lit_sr = {lit_sr[14:0], lit};
               end
            end
         end
         chk("t6_frame_we", we_seen - w0, 1);
         chk("t6_frame_row", hit_row, 7);
         chk("t6_frame_col", hit_col, 0);
      end

      // Drive the hit counter through its wrap on pixel (7,0)
      repeat (10) step(1'b0, 1'b1, 8'h80, 8'h01);
      iter = 0;
      while (m_cnt != 8'd255 && iter < 300) begin
         pulse();
         iter++;
      end
      chk("t6_wrap_bound", (iter < 300), 1);
      chk("t6_wrap_pre", hit_cnt, 255);
      w0 = we_seen;
      pulse();
      chk("t6_wrap_we", we_seen - w0, 1);
      chk("t6_wrap_zero", hit_cnt, 0);
      chk("t6_wrap_row", hit_row, 7);

      repeat (5) step(1'b0, 1'b1, 8'h00, 8'h00);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
